nco_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler for the NCO core. It drives the NCO's phase-increment and clock-enable inputs to step a linear frequency ramp: it starts at a programmed increment, adds a fixed step after each dwell period, and runs for a programmed number of steps, either once or repeating. After the last step it keeps the NCO clocked long enough to flush its output pipeline, then signals completion. It sits between the register/control interface and the NCO instance and is the only driver of `phi_inc_i` and `clken` on that instance.

---
 rtl/nco_sweep_ctrl_if.sv | 33 +++
 rtl/nco_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between the register block (master) and the NCO sweep
// scheduler (slave): sweep configuration in, NCO drive and sweep status out.
interface nco_sweep_ctrl_if #(
  parameter int apr = 32,
  parameter int cw  = 16
);
  logic           start;
  logic           abort;
  logic           ext_en;
  logic [apr-1:0] cfg_start_inc;
  logic [apr-1:0] cfg_step;
  logic [cw-1:0]  cfg_num_steps;
  logic [cw-1:0]  cfg_dwell;
  logic           cfg_repeat;
  logic [apr-1:0] phi_inc_o;
  logic           nco_clken;
  logic           step_strobe;
  logic [cw-1:0]  step_idx;
  logic           busy;
  logic           done;

  modport master (
    output start, abort, ext_en, cfg_start_inc, cfg_step, cfg_num_steps,
           cfg_dwell, cfg_repeat,
    input  phi_inc_o, nco_clken, step_strobe, step_idx, busy, done
  );

  modport slave (
    input  start, abort, ext_en, cfg_start_inc, cfg_step, cfg_num_steps,
           cfg_dwell, cfg_repeat,
    output phi_inc_o, nco_clken, step_strobe, step_idx, busy, done
  );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep scheduler: steps the NCO phase increment through a
// ramp of dwell periods, then keeps the NCO clocked to flush its pipeline.
module nco_sweep_ctrl #(
  parameter int apr = 32,
  parameter int cw  = 16,
  parameter int lat = 6
) (
  input logic             clk,
  input logic             reset,
  nco_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  localparam logic [cw-1:0] FLUSH_LD = cw'(lat - 1);

  state_t         r_state;
  logic [apr-1:0] r_phi;
  logic [apr-1:0] r_start_inc;
  logic [apr-1:0] r_step;
  logic [cw-1:0]  r_last_idx;
  logic [cw-1:0]  r_dwell_ld;
  logic           r_repeat;
  logic [cw-1:0]  r_dwell_cnt;
  logic [cw-1:0]  r_flush_cnt;
  logic [cw-1:0]  r_step_idx;
  logic           r_clken;
  logic           r_strobe;
  logic           r_busy;
  logic           r_done;

  // Counters hold "remaining minus one", so a zero config means a single cycle/step.
  logic [cw-1:0] w_cfg_last_idx;
  logic [cw-1:0] w_cfg_dwell_ld;
  assign w_cfg_last_idx = (bus.cfg_num_steps == '0) ? '0 : bus.cfg_num_steps - 1'b1;
  assign w_cfg_dwell_ld = (bus.cfg_dwell == '0) ? '0 : bus.cfg_dwell - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phi       <= '0;
      r_start_inc <= '0;
      r_step      <= '0;
      r_last_idx  <= '0;
      r_dwell_ld  <= '0;
      r_repeat    <= 1'b0;
      r_dwell_cnt <= '0;
      r_flush_cnt <= '0;
      r_step_idx  <= '0;
      r_clken     <= 1'b0;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clken <= 1'b0;
          if (bus.start && !bus.abort) begin
            r_start_inc <= bus.cfg_start_inc;
            r_step      <= bus.cfg_step;
            r_last_idx  <= w_cfg_last_idx;
            r_dwell_ld  <= w_cfg_dwell_ld;
            r_repeat    <= bus.cfg_repeat;
            r_phi       <= bus.cfg_start_inc;
            r_step_idx  <= '0;
            r_dwell_cnt <= w_cfg_dwell_ld;
            r_strobe    <= 1'b1;
            r_busy      <= 1'b1;
            r_clken     <= bus.ext_en;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_state    <= S_IDLE;
            r_phi      <= '0;
            r_clken    <= 1'b0;
            r_busy     <= 1'b0;
            r_step_idx <= '0;
          end else begin
            r_clken <= bus.ext_en;
            if (bus.ext_en) begin
              if (r_dwell_cnt != '0) begin
                r_dwell_cnt <= r_dwell_cnt - 1'b1;
              end else if (r_step_idx != r_last_idx) begin
                r_phi       <= r_phi + r_step;
                r_step_idx  <= r_step_idx + 1'b1;
                r_dwell_cnt <= r_dwell_ld;
                r_strobe    <= 1'b1;
              end else if (r_repeat) begin
                r_phi       <= r_start_inc;
                r_step_idx  <= '0;
                r_dwell_cnt <= r_dwell_ld;
                r_strobe    <= 1'b1;
              end else if (lat == 0) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_clken <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state     <= S_FLUSH;
                r_flush_cnt <= FLUSH_LD;
              end
            end
          end
        end
        S_FLUSH: begin
          if (bus.abort) begin
            r_state    <= S_IDLE;
            r_phi      <= '0;
            r_clken    <= 1'b0;
            r_busy     <= 1'b0;
            r_step_idx <= '0;
          end else begin
            r_clken <= bus.ext_en;
            if (bus.ext_en) begin
              if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_clken <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.phi_inc_o   = r_phi;
  assign bus.nco_clken   = r_clken;
  assign bus.step_strobe = r_strobe;
  assign bus.step_idx    = r_step_idx;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: expected outputs come from a count of
// enabled cycles since start, pushed per cycle and compared after each edge.
module tb_nco_sweep_ctrl;
  localparam int APR = 32;
  localparam int CW  = 16;
  localparam int LAT = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nco_sweep_ctrl_if #(.apr(APR), .cw(CW)) bus();

  nco_sweep_ctrl #(.apr(APR), .cw(CW), .lat(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] phi;
    logic [15:0] idx;
    logic        clken;
    logic        strobe;
    logic        busy;
    logic        done;
    bit          chk_phi;
    bit          chk_idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, want);
    end
  endtask

  function automatic exp_t idle_exp(input string tag, input bit chk_phi, input bit chk_idx);
    exp_t e;
    e.tag = tag; e.phi = '0; e.idx = '0;
    e.clken = 1'b0; e.strobe = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    e.chk_phi = chk_phi; e.chk_idx = chk_idx;
    return e;
  endfunction

  task automatic tick_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, ".clken"},  32'(bus.nco_clken),   32'(e.clken));
    chk({e.tag, ".strobe"}, 32'(bus.step_strobe), 32'(e.strobe));
    chk({e.tag, ".busy"},   32'(bus.busy),        32'(e.busy));
    chk({e.tag, ".done"},   32'(bus.done),        32'(e.done));
    if (e.chk_phi) chk({e.tag, ".phi"}, bus.phi_inc_o, e.phi);
    if (e.chk_idx) chk({e.tag, ".idx"}, 32'(bus.step_idx), 32'(e.idx));
  endtask

  task automatic drive_idle();
    bus.start = 1'b0; bus.abort = 1'b0; bus.ext_en = 1'b1;
  endtask

  // stop_j < 0 runs to done plus two idle cycles; otherwise stops after stop_j cycles.
  task automatic run_sweep(input string tag, input logic [31:0] si, input logic [31:0] st,
                           input logic [15:0] n, input logic [15:0] d, input logic rpt,
                           input int pause_at, input int pause_len, input int stop_j);
    int   n_eff, d_eff, nd, total, p, s, idle_left, done_off;
    bit   fin;
    logic en;
    exp_t e;
    n_eff = (n == 0) ? 1 : int'(n);
    d_eff = (d == 0) ? 1 : int'(d);
    nd = n_eff * d_eff;
    total = nd + LAT;
    p = 0; fin = 0; idle_left = 2; done_off = -1;
    bus.abort = 1'b0;
    bus.cfg_start_inc = si; bus.cfg_step = st;
    bus.cfg_num_steps = n; bus.cfg_dwell = d; bus.cfg_repeat = rpt;
    for (int j = 0; j < 400; j++) begin
      if (stop_j >= 0 && j >= stop_j) break;
      if (fin && idle_left == 0) break;
      en = (j == 0) ? 1'b1 : !(j >= pause_at && j < pause_at + pause_len);
      bus.ext_en = en;
      bus.start = (j == 0) || (j == 2);
      if (j == 1) begin
        bus.cfg_start_inc = ~si; bus.cfg_step = ~st;
        bus.cfg_num_steps = n + 16'd3; bus.cfg_dwell = d + 16'd2; bus.cfg_repeat = ~rpt;
      end
      if (fin) begin
        e = idle_exp(tag, 0, 0);
        idle_left--;
      end else begin
        if (j > 0 && en) p++;
        e.tag = tag; e.chk_phi = 1; e.chk_idx = 1;
        e.clken = en; e.busy = 1'b1; e.done = 1'b0;
        e.strobe = (j == 0) || (en && (p % d_eff == 0) && (rpt || p < nd));
        if (rpt || p < nd) begin
          s = (p / d_eff) % n_eff;
          e.phi = si + st * 32'(s);
          e.idx = 16'(s);
        end else if (p < total) begin
          e.phi = si + st * 32'(n_eff - 1);
          e.idx = 16'(n_eff - 1);
        end else begin
          e = idle_exp(tag, 0, 0);
          e.done = 1'b1;
          fin = 1;
          done_off = j + 1;
        end
      end
      sb_q.push_back(e);
      tick_and_check();
    end
    bus.start = 1'b0;
    bus.ext_en = 1'b1;
    if (stop_j < 0 && !fin) chk({tag, ".done_seen"}, 32'd0, 32'd1);
    $display("sweep %s: start=0x%08h step=0x%08h N=%0d D=%0d rpt=%0d done_offset=%0d",
             tag, si, st, n, d, rpt, done_off);
  endtask

  initial begin
    bus.cfg_start_inc = '0; bus.cfg_step = '0; bus.cfg_num_steps = '0;
    bus.cfg_dwell = '0; bus.cfg_repeat = 1'b0;
    drive_idle();
    reset = 1'b1;
    sb_q.push_back(idle_exp("reset", 1, 1));
    tick_and_check();
    sb_q.push_back(idle_exp("reset", 1, 1));
    tick_and_check();
    reset = 1'b0;
    $display("reset: outputs checked at zero");

    run_sweep("single", 32'h1000_0000, 32'h0100_0000, 16'd4, 16'd3, 1'b0, 1000, 0, -1);
    run_sweep("wrap",   32'hFFFF_FFF0, 32'h0000_0010, 16'd3, 16'd2, 1'b0, 1000, 0, -1);
    run_sweep("down",   32'h0000_0005, 32'hFFFF_FFFF, 16'd3, 16'd2, 1'b0, 1000, 0, -1);

    // Repeat never completes; abort must drop to IDLE with zero increment and no done.
    run_sweep("repeat", 32'h2000_0000, 32'h0100_0000, 16'd2, 16'd2, 1'b1, 1000, 0, 12);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    sb_q.push_back(idle_exp("abort", 1, 0));
    tick_and_check();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(idle_exp("post_abort", 1, 0));
      tick_and_check();
    end
    $display("abort: checked idle, phi=0, no done");

    run_sweep("pause",  32'h1000_0000, 32'h0100_0000, 16'd4, 16'd3, 1'b0, 4, 5, -1);
    run_sweep("degen",  32'h3000_0000, 32'h0000_0001, 16'd0, 16'd0, 1'b0, 1000, 0, -1);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    sb_q.push_back(idle_exp("start_abort", 0, 0));
    tick_and_check();
    drive_idle();
    sb_q.push_back(idle_exp("start_abort_next", 0, 0));
    tick_and_check();
    $display("start+abort: checked no transition");

    run_sweep("pre_reset", 32'h1000_0000, 32'h0100_0000, 16'd4, 16'd3, 1'b0, 1000, 0, 15);
    reset = 1'b1;
    sb_q.push_back(idle_exp("flush_reset", 1, 1));
    tick_and_check();
    reset = 1'b0;
    $display("reset in flush: outputs checked at zero");
    run_sweep("after_reset", 32'h1000_0000, 32'h0100_0000, 16'd4, 16'd3, 1'b0, 1000, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
